// File: rtl/lcd_pkg.sv
// Purpose: shared types, init ROM and post-byte wait rule for the HD44780 4-bit LCD controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package lcd_pkg;

    // Top-level sequencer states. XFER covers the SETUP/EN_HI/EN_LO phases of one or two
    // nibbles, which lcd_nibble_tx tracks in its own nib_state_t.
    typedef enum logic [2:0] {
        ST_POR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_XFER,
        ST_WAIT
    } top_state_t;

    typedef enum logic [1:0] {
        NB_IDLE,
        NB_SETUP,
        NB_EN_HI,
        NB_EN_LO
    } nib_state_t;

    // Power-on init: four single nibbles (element 0 goes out first), then four full bytes.
    localparam logic [3:0][3:0] INIT_NIBBLES = {4'h2, 4'h3, 4'h3, 4'h3};
    localparam logic [3:0][7:0] INIT_BYTES   = {8'h01, 8'h06, 8'h0C, 8'h28};

    // Commands that need the long post-command delay.
    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_HOME_ALT = 8'h03;

    function automatic int unsigned post_byte_wait(
        input logic        rs,
        input logic [7:0]  dat,
        input int unsigned cmd_wait,
        input int unsigned clr_wait
    );
        if (!rs && (dat == OP_CLEAR || dat == OP_HOME || dat == OP_HOME_ALT))
            return clr_wait;
        return cmd_wait;
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Purpose: drives one LCD nibble: 1-cycle SETUP, EN_CYCLES with lcd_en high, EN_CYCLES low.
// Latency: lcd_rs/lcd_data load on the start edge; lcd_en rises one cycle later.
// Backpressure: start is honoured only when idle or on the done cycle (back-to-back nibbles).
// Ports: clk, rst_n; start/rs/nibble (request); lcd_rs/lcd_en/lcd_data (pins); done (pulse on last EN_LO cycle).
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int EN_CYCLES = 800
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [3:0] nibble,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [3:0] lcd_data,
    output logic       done
);

    localparam int             CW      = $clog2(EN_CYCLES + 1);
    localparam logic [CW-1:0]  EN_LAST = CW'(EN_CYCLES - 1);

    nib_state_t    state;
    logic [CW-1:0] cnt;

    assign done = (state == NB_EN_LO) && (cnt == EN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= NB_IDLE;
            cnt      <= '0;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_data <= '0;
        end else begin
            case (state)
                NB_SETUP: begin
                    state  <= NB_EN_HI;
                    cnt    <= '0;
                    lcd_en <= 1'b1;
                end
                NB_EN_HI: begin
                    if (cnt == EN_LAST) begin
                        state  <= NB_EN_LO;
                        cnt    <= '0;
                        lcd_en <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                NB_EN_LO: begin
                    if (cnt == EN_LAST) begin
                        cnt <= '0;
                        // A start on the done cycle chains the next nibble with no gap.
                        if (start) begin
                            state    <= NB_SETUP;
                            lcd_rs   <= rs;
                            lcd_data <= nibble;
                        end else begin
                            state <= NB_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state    <= NB_SETUP;
                        cnt      <= '0;
                        lcd_rs   <= rs;
                        lcd_data <= nibble;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_arbiter.sv
// Purpose: HD44780 4-bit controller: runs the power-on init, then round-robins two byte requesters onto the LCD.
// Latency: accept -> lcd_en high on the 2nd cycle; a byte holds the bus 2*(1+2*EN_CYCLES)+wait cycles.
// Backpressure: reqN_ready is only offered in IDLE after init; requesters hold valid/data until ready.
// Ports: clk, rst_n; reqN_valid/reqN_rs/reqN_data/reqN_ready (N=0,1); lcd_rs/lcd_en/lcd_data; init_done; busy.
module lcd_arbiter
    import lcd_pkg::*;
#(
    parameter int EN_CYCLES = 800,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 60000,
    parameter int POR_WAIT  = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [7:4] lcd_data,
    output logic       init_done,
    output logic       busy
);

    localparam int MAX_A   = (POR_WAIT > CLR_WAIT) ? POR_WAIT : CLR_WAIT;
    localparam int MAX_B   = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
    localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] POR_LAST = CW'(POR_WAIT - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_ALL);

    top_state_t    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] wait_len;
    logic [3:0]    init_idx;      // 0-3 single nibbles, 4-7 bytes, 8 = sequence finished
    logic          last_grant;    // 1 = req1 won last, so req0 wins the next tie
    logic          byte_rs;
    logic [7:0]    byte_dat;
    logic          second_nib;    // low nibble of byte_dat still to send

    logic          arb_open;
    logic          acc0;
    logic          acc1;
    logic          accept;
    logic          acc_rs;
    logic [7:0]    acc_dat;
    logic [7:0]    rom_byte;

    logic          tx_start;
    logic          tx_rs;
    logic [3:0]    tx_nib;
    logic          tx_done;

    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    // Ready depends only on state, pointer and the valids.
    assign arb_open   = (state == ST_IDLE) && init_done;
    assign req0_ready = arb_open && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = arb_open && req1_valid && (!req0_valid || !last_grant);

    assign acc0     = req0_valid && req0_ready;
    assign acc1     = req1_valid && req1_ready;
    assign accept   = acc0 || acc1;
    assign acc_rs   = acc1 ? req1_rs : req0_rs;
    assign acc_dat  = acc1 ? req1_data : req0_data;
    assign rom_byte = INIT_BYTES[init_idx[1:0]];

    // The first nibble launches on the same edge the byte is taken so SETUP follows immediately.
    always_comb begin
        tx_start = 1'b0;
        tx_rs    = byte_rs;
        tx_nib   = byte_dat[3:0];
        case (state)
            ST_INIT: begin
                tx_start = 1'b1;
                tx_rs    = 1'b0;
                tx_nib   = init_idx[2] ? rom_byte[7:4] : INIT_NIBBLES[init_idx[1:0]];
            end
            ST_IDLE: begin
                if (accept) begin
                    tx_start = 1'b1;
                    tx_rs    = acc_rs;
                    tx_nib   = acc_dat[7:4];
                end
            end
            ST_XFER: tx_start = tx_done && second_nib;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_POR_WAIT;
            cnt        <= '0;
            wait_len   <= '0;
            init_idx   <= '0;
            init_done  <= 1'b0;
            busy       <= 1'b1;
            last_grant <= 1'b1;
            byte_rs    <= 1'b0;
            byte_dat   <= '0;
            second_nib <= 1'b0;
        end else begin
            case (state)
                ST_POR_WAIT: begin
                    if (cnt == POR_LAST) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_INIT: begin
                    state    <= ST_XFER;
                    cnt      <= '0;
                    init_idx <= init_idx + 4'd1;
                    byte_rs  <= 1'b0;
                    if (init_idx[2]) begin
                        byte_dat   <= rom_byte;
                        second_nib <= 1'b1;
                        wait_len   <= CW'(post_byte_wait(1'b0, rom_byte, CMD_WAIT, CLR_WAIT));
                    end else begin
                        second_nib <= 1'b0;
                        wait_len   <= CW'(CLR_WAIT);
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_XFER;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        last_grant <= acc1;
                        byte_rs    <= acc_rs;
                        byte_dat   <= acc_dat;
                        second_nib <= 1'b1;
                        wait_len   <= CW'(post_byte_wait(acc_rs, acc_dat, CMD_WAIT, CLR_WAIT));
                    end
                end
                ST_XFER: begin
                    if (tx_done) begin
                        if (second_nib) begin
                            second_nib <= 1'b0;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == wait_len - 1'b1) begin
                        cnt <= '0;
                        if (init_done || init_idx == 4'd8) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            init_done <= 1'b1;
                        end else begin
                            state <= ST_INIT;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= ST_POR_WAIT;
            endcase
        end
    end

    lcd_nibble_tx #(
        .EN_CYCLES (EN_CYCLES)
    ) u_nibble_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tx_start),
        .rs       (tx_rs),
        .nibble   (tx_nib),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_lcd_arbiter.sv
// Purpose: directed self-checking bench for lcd_arbiter with shortened timing parameters.
// Latency: expectations are derived from 1 + 2*4 cycles per nibble plus 10/50-cycle waits.
// Backpressure: requesters hold valid until accepted, then drop it on the following cycle.
module tb_lcd_arbiter;

    localparam int EN_CYCLES = 4;
    localparam int CMD_WAIT  = 10;
    localparam int CLR_WAIT  = 50;
    localparam int POR_WAIT  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic       req0_rs = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic       req1_rs = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       lcd_rs;
    logic       lcd_en;
    logic [7:4] lcd_data;
    logic       init_done;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lcd_arbiter #(
        .EN_CYCLES (EN_CYCLES),
        .CMD_WAIT  (CMD_WAIT),
        .CLR_WAIT  (CLR_WAIT),
        .POR_WAIT  (POR_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .lcd_rs     (lcd_rs),
        .lcd_en     (lcd_en),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .busy       (busy)
    );

    // Bus monitor, sampled on the falling edge.
    int         nc = 0;
    logic       en_prev = 1'b0;
    logic       busy_prev = 1'b1;
    logic       init_prev = 1'b0;
    int         hi_len = 0;
    int         last_fall = -1;
    int         busy_fall = -1;
    int         init_rises = 0;
    logic [4:0] nib_q[$];
    int         width_q[$];
    int         rise_q[$];
    int         acc_id_q[$];
    int         acc_neg_q[$];
    logic       acc_first_q[$];

    always @(negedge clk) begin
        nc++;
        if (!rst_n) begin
            en_prev   = 1'b0;
            busy_prev = 1'b1;
            init_prev = 1'b0;
            hi_len    = 0;
        end else begin
            if (lcd_en && !en_prev) begin
                nib_q.push_back({lcd_rs, lcd_data});
                rise_q.push_back(nc);
            end
            if (lcd_en) hi_len++;
            if (!lcd_en && en_prev) begin
                width_q.push_back(hi_len);
                hi_len    = 0;
                last_fall = nc;
            end
            if (!busy && busy_prev) busy_fall = nc;
            if (init_done && !init_prev) init_rises++;
            if (req0_valid && req0_ready) begin
                acc_id_q.push_back(0);
                acc_neg_q.push_back(nc);
                acc_first_q.push_back(busy_prev);
            end
            if (req1_valid && req1_ready) begin
                acc_id_q.push_back(1);
                acc_neg_q.push_back(nc);
                acc_first_q.push_back(busy_prev);
            end
            en_prev   = lcd_en;
            busy_prev = busy;
            init_prev = init_done;
        end
    end

    function automatic logic [4:0] init_exp(input int i);
        case (i)
            0, 1, 2: return 5'h03;
            3:       return 5'h02;
            4:       return 5'h02;
            5:       return 5'h08;
            6:       return 5'h00;
            7:       return 5'h0C;
            8:       return 5'h00;
            9:       return 5'h06;
            10:      return 5'h00;
            default: return 5'h01;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        nib_q.delete();
        width_q.delete();
        rise_q.delete();
        acc_id_q.delete();
        acc_neg_q.delete();
        acc_first_q.delete();
        last_fall = -1;
        busy_fall = -1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_rs    = 1'b1;
        req0_data  = 8'h41;
        req1_valid = 1'b1;
        repeat (3) tick();
        checks++; if (lcd_en !== 1'b0)    begin errors++; $display("FAIL reset_lcd_en: got %b want 0", lcd_en); end
        checks++; if (lcd_rs !== 1'b0)    begin errors++; $display("FAIL reset_lcd_rs: got %b want 0", lcd_rs); end
        checks++; if (lcd_data !== 4'h0)  begin errors++; $display("FAIL reset_lcd_data: got %h want 0", lcd_data); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
        req1_valid = 1'b0;
    endtask

    // req0 holds 0x41 (rs=1) throughout init; it must not be granted until init_done.
    task automatic test_init();
        logic early;
        int   bad;
        early = 1'b0;
        clear_mon();
        init_rises = 0;
        drive_edge();
        rst_n = 1'b1;
        for (int i = 0; i < 3000 && !init_done; i++) begin
            tick();
            if (!init_done && req0_ready) early = 1'b1;
        end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_timeout: init_done=%b want 1", init_done); end
        checks++; if (early) begin errors++; $display("FAIL init_early_ready: req0_ready went 1 before init_done"); end
        checks++; if (nib_q.size() != 12) begin errors++; $display("FAIL init_nibble_count: got %0d want 12", nib_q.size()); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (i >= nib_q.size() || nib_q[i] !== init_exp(i)) begin
                errors++;
                $display("FAIL init_nibble[%0d]: got %h want %h", i, (i < nib_q.size()) ? nib_q[i] : 5'h1F, init_exp(i));
            end
        end
        bad = 0;
        foreach (width_q[i]) if (width_q[i] != EN_CYCLES) bad++;
        checks++; if (bad != 0 || width_q.size() != 12) begin errors++; $display("FAIL init_en_width: %0d bad of %0d pulses, want 12 of width 4", bad, width_q.size()); end
        checks++; if (init_rises != 1) begin errors++; $display("FAIL init_done_rises: got %0d want 1", init_rises); end
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL init_first_grant: req0_ready=%b want 1", req0_ready); end
        drive_edge();
        req0_valid = 1'b0;
    endtask

    // Continues the 0x41 byte accepted on the first IDLE cycle after init.
    task automatic test_char();
        int acc;
        for (int i = 0; i < 200 && busy; i++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL char_busy_timeout: busy=%b want 0", busy); end
        acc = (acc_neg_q.size() > 0) ? acc_neg_q[0] : -1000;
        checks++; if (acc_id_q.size() != 1 || acc_id_q[0] != 0) begin errors++; $display("FAIL char_accept: %0d accepts, want one from req0", acc_id_q.size()); end
        checks++; if (nib_q.size() != 14) begin errors++; $display("FAIL char_nibble_count: got %0d want 14", nib_q.size()); end
        checks++; if (nib_q.size() < 13 || nib_q[12] !== 5'h14) begin errors++; $display("FAIL char_hi_nibble: got %h want 14", (nib_q.size() > 12) ? nib_q[12] : 5'h1F); end
        checks++; if (nib_q.size() < 14 || nib_q[13] !== 5'h11) begin errors++; $display("FAIL char_lo_nibble: got %h want 11", (nib_q.size() > 13) ? nib_q[13] : 5'h1F); end
        checks++; if (rise_q.size() < 13 || rise_q[12] - acc != 2) begin errors++; $display("FAIL char_en_latency: got %0d want 2", (rise_q.size() > 12) ? rise_q[12] - acc : -1); end
        checks++; if (busy_fall - acc != 29) begin errors++; $display("FAIL char_busy_fall: got %0d cycles after accept, want 29", busy_fall - acc); end
        checks++; if (busy_fall - last_fall != EN_CYCLES + CMD_WAIT) begin errors++; $display("FAIL char_wait: busy fell %0d after last en fall, want 14", busy_fall - last_fall); end
        checks++; if (width_q.size() != 14 || width_q[13] != EN_CYCLES) begin errors++; $display("FAIL char_en_width: %0d pulses, want 14 of width 4", width_q.size()); end
        checks++; if (init_done !== 1'b1 || init_rises != 1) begin errors++; $display("FAIL char_init_hold: init_done=%b rises=%0d want 1/1", init_done, init_rises); end
    endtask

    // Clear (long wait) then set-DDRAM (short wait), both from req1.
    task automatic test_commands();
        logic [7:0] cmd;
        int         exp_fall;
        int         acc;
        for (int k = 0; k < 2; k++) begin
            cmd      = (k == 0) ? 8'h01 : 8'h80;
            exp_fall = 2 * (1 + 2 * EN_CYCLES) + ((k == 0) ? CLR_WAIT : CMD_WAIT) + 1;
            clear_mon();
            drive_edge();
            req1_rs    = 1'b0;
            req1_data  = cmd;
            req1_valid = 1'b1;
            for (int i = 0; i < 100 && acc_id_q.size() == 0; i++) tick();
            drive_edge();
            req1_valid = 1'b0;
            for (int i = 0; i < 300 && busy; i++) tick();
            acc = (acc_neg_q.size() > 0) ? acc_neg_q[0] : -1000;
            checks++; if (acc_id_q.size() != 1 || acc_id_q[0] != 1) begin errors++; $display("FAIL cmd%0d_accept: %0d accepts, want one from req1", k, acc_id_q.size()); end
            checks++; if (nib_q.size() != 2 || nib_q[0] !== {1'b0, cmd[7:4]} || nib_q[1] !== {1'b0, cmd[3:0]}) begin
                errors++; $display("FAIL cmd%0d_nibbles: %0d nibbles, want %h then %h", k, nib_q.size(), {1'b0, cmd[7:4]}, {1'b0, cmd[3:0]});
            end
            checks++; if (busy_fall - acc != exp_fall) begin errors++; $display("FAIL cmd%0d_wait: busy fell %0d after accept, want %0d", k, busy_fall - acc, exp_fall); end
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_nib;
        clear_mon();
        drive_edge();
        req0_rs    = 1'b1;
        req0_data  = 8'h30;
        req1_rs    = 1'b1;
        req1_data  = 8'h31;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 500 && acc_id_q.size() < 4; i++) tick();
        drive_edge();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 200 && busy; i++) tick();
        checks++; if (acc_id_q.size() != 4) begin errors++; $display("FAIL rr_count: got %0d accepts want 4", acc_id_q.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= acc_id_q.size() || acc_id_q[k] != (k % 2)) begin
                errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, (k < acc_id_q.size()) ? acc_id_q[k] : -1, k % 2);
            end
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (k >= acc_first_q.size() || acc_first_q[k] !== 1'b1) begin
                errors++; $display("FAIL rr_first_idle[%0d]: accept not on first IDLE cycle", k);
            end
        end
        checks++; if (nib_q.size() != 8) begin errors++; $display("FAIL rr_nibble_count: got %0d want 8", nib_q.size()); end
        for (int k = 0; k < 8; k++) begin
            exp_nib = (k % 2 == 0) ? 5'h13 : ((k % 4 == 1) ? 5'h10 : 5'h11);
            checks++;
            if (k >= nib_q.size() || nib_q[k] !== exp_nib) begin
                errors++; $display("FAIL rr_nibble[%0d]: got %h want %h", k, (k < nib_q.size()) ? nib_q[k] : 5'h1F, exp_nib);
            end
        end
    endtask

    task automatic test_busy_pulse();
        clear_mon();
        drive_edge();
        req0_rs    = 1'b1;
        req0_data  = 8'h55;
        req0_valid = 1'b1;
        for (int i = 0; i < 100 && acc_id_q.size() == 0; i++) tick();
        drive_edge();
        req0_valid = 1'b0;
        drive_edge();
        req1_rs    = 1'b1;
        req1_data  = 8'hA5;
        req1_valid = 1'b1;
        tick();
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL pulse_ready: req1_ready=%b while busy, want 0", req1_ready); end
        drive_edge();
        req1_valid = 1'b0;
        for (int i = 0; i < 200 && busy; i++) tick();
        repeat (40) tick();
        checks++; if (acc_id_q.size() != 1) begin errors++; $display("FAIL pulse_accepts: got %0d want 1", acc_id_q.size()); end
        checks++; if (nib_q.size() != 2 || nib_q[0] !== 5'h15 || nib_q[1] !== 5'h15) begin
            errors++; $display("FAIL pulse_nibbles: got %0d nibbles, want exactly 15 15", nib_q.size());
        end
    endtask

    task automatic test_reset_mid_strobe();
        clear_mon();
        drive_edge();
        req0_rs    = 1'b1;
        req0_data  = 8'h48;
        req0_valid = 1'b1;
        for (int i = 0; i < 100 && acc_id_q.size() == 0; i++) tick();
        drive_edge();
        req0_valid = 1'b0;
        for (int i = 0; i < 100 && nib_q.size() < 2; i++) tick();
        tick();
        checks++; if (lcd_en !== 1'b1 || nib_q.size() != 2 || nib_q[1] !== 5'h18) begin
            errors++; $display("FAIL midrst_setup: lcd_en=%b nibbles=%0d, want en=1 during 2nd nibble 18", lcd_en, nib_q.size());
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (lcd_en !== 1'b0)    begin errors++; $display("FAIL midrst_en_async: got %b want 0", lcd_en); end
        checks++; if (busy !== 1'b1 || init_done !== 1'b0) begin errors++; $display("FAIL midrst_status: busy=%b init_done=%b want 1/0", busy, init_done); end
        repeat (3) tick();
        clear_mon();
        init_rises = 0;
        drive_edge();
        rst_n = 1'b1;
        for (int i = 0; i < 3000 && !init_done; i++) tick();
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL midrst_init_timeout: init_done=%b want 1", init_done); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (i >= nib_q.size() || nib_q[i] !== init_exp(i)) begin
                errors++; $display("FAIL midrst_init_nibble[%0d]: got %h want %h", i, (i < nib_q.size()) ? nib_q[i] : 5'h1F, init_exp(i));
            end
        end
        repeat (100) tick();
        checks++; if (nib_q.size() != 12 || acc_id_q.size() != 0) begin
            errors++; $display("FAIL midrst_no_resend: nibbles=%0d accepts=%0d want 12/0", nib_q.size(), acc_id_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_char();
        test_commands();
        test_round_robin();
        test_busy_pulse();
        test_reset_mid_strobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
